ac_cooling_sequencer: RTL and testbench

Sequences the AC fan and compressor from the registered mode code produced by the mode-selection block (00 OFF, 01 AUTOMATIC, 10 FAST_COOL, 11 ECO), the room temperature and the user setpoint. Applies per-mode thresholds with hysteresis. Enforces fan lead before compressor start, compressor minimum run time, fan run-on after compressor stop, and compressor minimum off time. All durations count a 1-per-tick timebase enable.

---
 rtl/ac_cooling_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ac_cooling_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ac_cooling_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ac_cooling_sequencer
// Brief    : Fan/compressor sequencer with per-mode hysteresis thresholds,
//            fan lead/lag, compressor minimum run and minimum off lockout.
// Revision : 1.0 - initial release
// ============================================================================
module ac_cooling_sequencer #(
  parameter int FAN_LEAD    = 2,
  parameter int MIN_ON      = 5,
  parameter int FAN_LAG     = 3,
  parameter int MIN_OFF     = 6,
  parameter int HYST        = 2,
  parameter int ECO_OFFSET  = 3,
  parameter int FAST_OFFSET = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] mode,
  input  logic [7:0] room_temp,
  input  logic [7:0] setpoint,
  output logic       compressor_on,
  output logic [1:0] fan_speed,
  output logic       fan_on,
  output logic [2:0] state
);

  localparam int CNT_W = 16;

  localparam logic [1:0] C_MODE_OFF  = 2'b00;
  localparam logic [1:0] C_MODE_FAST = 2'b10;
  localparam logic [1:0] C_MODE_ECO  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_COOL = 3'd2,
    ST_LAG  = 3'd3,
    ST_REST = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_dur_cnt;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             r_compressor_on;
  logic [1:0]       r_fan_speed;
  logic             r_fan_on;

  logic             w_load_dur;
  logic [CNT_W-1:0] w_dur_val;
  logic             w_load_lock;
  logic             w_comp;
  logic [1:0]       w_fan;
  logic [1:0]       w_run_speed;
  logic [9:0]       w_sp;
  logic [9:0]       w_room;
  logic [9:0]       w_eco;
  logic [9:0]       w_target;
  logic             w_call_on;
  logic             w_call_off;
  logic             w_dur_exp;
  logic             w_lock_exp;

  // Thresholds are kept wider than the inputs so clamping and the
  // on-threshold sum never wrap.
  assign w_sp   = {2'b00, setpoint};
  assign w_room = {2'b00, room_temp};
  assign w_eco  = w_sp + 10'(ECO_OFFSET);

  always_comb begin
    w_target    = w_sp;
    w_run_speed = 2'd2;
    case (mode)
      C_MODE_FAST: begin
        w_target    = (w_sp >= 10'(FAST_OFFSET)) ? (w_sp - 10'(FAST_OFFSET)) : 10'd0;
        w_run_speed = 2'd3;
      end
      C_MODE_ECO: begin
        w_target    = (w_eco > 10'd255) ? 10'd255 : w_eco;
        w_run_speed = 2'd1;
      end
      default: begin
        w_target    = w_sp;
        w_run_speed = 2'd2;
      end
    endcase
  end

  assign w_call_on  = (mode != C_MODE_OFF) && (w_room >= (w_target + 10'(HYST)));
  assign w_call_off = (mode != C_MODE_OFF) && (w_room <= w_target);
  assign w_dur_exp  = (r_dur_cnt == '0);
  assign w_lock_exp = (r_lock_cnt == '0);

  always_comb begin
    w_next      = r_state;
    w_load_dur  = 1'b0;
    w_dur_val   = '0;
    w_load_lock = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_call_on && w_lock_exp) begin
          w_next     = ST_LEAD;
          w_load_dur = 1'b1;
          w_dur_val  = CNT_W'(FAN_LEAD);
        end
      end
      ST_LEAD: begin
        if (mode == C_MODE_OFF || !w_call_on) begin
          w_next = ST_IDLE;
        end else if (w_dur_exp) begin
          w_next     = ST_COOL;
          w_load_dur = 1'b1;
          w_dur_val  = CNT_W'(MIN_ON);
        end
      end
      ST_COOL: begin
        if (w_dur_exp && (w_call_off || mode == C_MODE_OFF)) begin
          w_next      = ST_LAG;
          w_load_dur  = 1'b1;
          w_dur_val   = CNT_W'(FAN_LAG);
          w_load_lock = 1'b1;
        end
      end
      ST_LAG: begin
        if (w_dur_exp) w_next = ST_REST;
      end
      ST_REST: begin
        if (w_lock_exp) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they move with the state.
  always_comb begin
    w_comp = 1'b0;
    w_fan  = 2'd0;
    case (w_next)
      ST_LEAD: w_fan = w_run_speed;
      ST_COOL: begin
        w_fan  = w_run_speed;
        w_comp = 1'b1;
      end
      ST_LAG:  w_fan = 2'd1;
      default: begin
        w_fan  = 2'd0;
        w_comp = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_dur_cnt       <= '0;
      r_lock_cnt      <= '0;
      r_compressor_on <= 1'b0;
      r_fan_speed     <= 2'd0;
      r_fan_on        <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_compressor_on <= w_comp;
      r_fan_speed     <= w_fan;
      r_fan_on        <= (w_fan != 2'd0);
      if (w_load_dur)
        r_dur_cnt <= w_dur_val;
      else if (tick && !w_dur_exp)
        r_dur_cnt <= r_dur_cnt - 1'b1;
      if (w_load_lock)
        r_lock_cnt <= CNT_W'(MIN_OFF);
      else if (tick && !w_lock_exp)
        r_lock_cnt <= r_lock_cnt - 1'b1;
    end
  end

  assign state         = r_state;
  assign compressor_on = r_compressor_on;
  assign fan_speed     = r_fan_speed;
  assign fan_on        = r_fan_on;

endmodule
`default_nettype wire

// File: tb/tb_ac_cooling_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac_cooling_sequencer
// Brief    : Randomized bench for ac_cooling_sequencer against an elapsed-tick
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ac_cooling_sequencer;

  localparam int FAN_LEAD    = 2;
  localparam int MIN_ON      = 5;
  localparam int FAN_LAG     = 3;
  localparam int MIN_OFF     = 6;
  localparam int HYST        = 2;
  localparam int ECO_OFFSET  = 3;
  localparam int FAST_OFFSET = 2;
  localparam int NCYC        = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] room_temp = 8'd0;
  logic [7:0] setpoint = 8'd0;
  logic       compressor_on;
  logic [1:0] fan_speed;
  logic       fan_on;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase plus ticks elapsed since phase entry / compressor stop
  int m_phase      = 0;
  int m_elapsed    = 0;
  bit m_stopped    = 1'b0;
  int m_since_stop = 0;
  int e_comp       = 0;
  int e_fan        = 0;
  bit e_fan_known  = 1'b1;

  int scen_sp   = 24;
  int scen_mode = 1;
  bit scen_tick_rand = 1'b0;

  always #5 clk = ~clk;

  ac_cooling_sequencer #(
    .FAN_LEAD(FAN_LEAD), .MIN_ON(MIN_ON), .FAN_LAG(FAN_LAG), .MIN_OFF(MIN_OFF),
    .HYST(HYST), .ECO_OFFSET(ECO_OFFSET), .FAST_OFFSET(FAST_OFFSET)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .mode(mode),
    .room_temp(room_temp),
    .setpoint(setpoint),
    .compressor_on(compressor_on),
    .fan_speed(fan_speed),
    .fan_on(fan_on),
    .state(state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_elapsed    = 0;
    m_stopped    = 1'b0;
    m_since_stop = 0;
    e_comp       = 0;
    e_fan        = 0;
    e_fan_known  = 1'b1;
  endtask

  task automatic model_edge();
    int  md, sp, rt, tgt, spd, nxt;
    bit  con, coff, lock_ok;
    md = int'(mode);
    sp = int'(setpoint);
    rt = int'(room_temp);
    case (md)
      2: begin tgt = (sp - FAST_OFFSET < 0) ? 0 : sp - FAST_OFFSET; spd = 3; end
      3: begin tgt = (sp + ECO_OFFSET > 255) ? 255 : sp + ECO_OFFSET; spd = 1; end
      default: begin tgt = sp; spd = 2; end
    endcase
    con     = (md != 0) && (rt >= tgt + HYST);
    coff    = (md != 0) && (rt <= tgt);
    lock_ok = !m_stopped || (m_since_stop >= MIN_OFF);
    nxt = m_phase;
    case (m_phase)
      0: if (con && lock_ok) nxt = 1;
      1: if (!con) nxt = 0; else if (m_elapsed >= FAN_LEAD) nxt = 2;
      2: if (m_elapsed >= MIN_ON && (coff || md == 0)) nxt = 3;
      3: if (m_elapsed >= FAN_LAG) nxt = 4;
      4: if (lock_ok) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_phase && nxt >= 1 && nxt <= 3) m_elapsed = 0;
    else if (tick) m_elapsed++;
    if (m_phase == 2 && nxt == 3) begin
      m_stopped    = 1'b1;
      m_since_stop = 0;
    end else if (tick) begin
      m_since_stop++;
    end
    m_phase     = nxt;
    e_comp      = (nxt == 2) ? 1 : 0;
    e_fan_known = !((nxt == 2) && (md == 0));
    e_fan       = (nxt == 1 || nxt == 2) ? spd : (nxt == 3) ? 1 : 0;
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  task automatic drive(input int cyc);
    if (cyc < 40) begin
      // Directed opening: start, minimum run, lockout, then abort paths
      tick = 1'b1;
      mode = 2'b01;
      setpoint = 8'd24;
      if (cyc < 4)       room_temp = 8'd26;
      else if (cyc < 8)  room_temp = 8'd24;
      else if (cyc < 25) room_temp = 8'd30;
      else if (cyc < 26) room_temp = 8'd30;
      else begin
        room_temp = 8'd30;
        if (cyc == 27) mode = 2'b00;
      end
    end else if (cyc < 60) begin
      tick = 1'b1;
      mode = (cyc < 50) ? 2'b11 : 2'b10;
      setpoint = (cyc < 45) ? 8'd24 : (cyc < 50) ? 8'd254 : (cyc < 55) ? 8'd1 : 8'd24;
      room_temp = (cyc < 42) ? 8'd28 : (cyc < 45) ? 8'd29 : (cyc < 50) ? 8'd255 :
                  (cyc < 55) ? 8'd2 : 8'd24;
    end else begin
      if (cyc % 40 == 0) begin
        case ($urandom % 6)
          0: scen_sp = 24;
          1: scen_sp = 1;
          2: scen_sp = 254;
          3: scen_sp = 0;
          4: scen_sp = 255;
          default: scen_sp = int'($urandom % 256);
        endcase
        scen_mode      = int'($urandom_range(1, 3));
        scen_tick_rand = ($urandom % 2) == 0;
        setpoint       = 8'(scen_sp);
        mode           = 2'(scen_mode);
      end
      if ($urandom % 25 == 0) mode = 2'($urandom % 4);
      if ($urandom % 30 == 0) setpoint = 8'(clamp8(int'(setpoint) + int'($urandom_range(0, 4)) - 2));
      if ($urandom % 6 == 0)
        room_temp = 8'(clamp8(int'(setpoint) + int'($urandom_range(0, 10)) - 4));
      tick = scen_tick_rand ? 1'($urandom % 2) : 1'b1;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check_eq("reset_state", 32'(state), 0);
    check_eq("reset_comp", 32'(compressor_on), 0);
    check_eq("reset_fan", 32'(fan_speed), 0);
    check_eq("reset_fan_on", 32'(fan_on), 0);
    model_reset();
    #1 rst = 1'b0;
    drive(0);
    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_eq("state", 32'(state), 32'(m_phase));
      check_eq("compressor_on", 32'(compressor_on), 32'(e_comp));
      if (e_fan_known) check_eq("fan_speed", 32'(fan_speed), 32'(e_fan));
      check_eq("fan_on", 32'(fan_on), 32'(fan_speed != 2'd0));
      if ((cyc == 6) || (cyc > 60 && $urandom % 150 == 0)) begin
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_state", 32'(state), 0);
        check_eq("async_rst_comp", 32'(compressor_on), 0);
        check_eq("async_rst_fan", 32'(fan_speed), 0);
        model_reset();
        rst = 1'b0;
      end
      @(negedge clk);
      drive(cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
